// File: rtl/noc_input_vc_unit_pkg.sv
// noc_input_vc_unit_pkg: NoC parameters, route/flit/VC-state enums and XY routing function
package noc_input_vc_unit_pkg;
  localparam int Noc_Flit_Width = 32;
  localparam int Noc_VC_Channel = 2;
  localparam int Noc_VC_Fifo_Depth = 4;
  localparam int Noc_ID_X_Width = 4;
  localparam int Noc_ID_Y_Width = 4;
  localparam int Noc_Dest_Point = 0;
  typedef enum logic [4:0] {
    ROUTE_NA = 5'b00000,
    EAST     = 5'b00001,
    WEST     = 5'b00010,
    SOUTH    = 5'b00100,
    NORTH    = 5'b01000,
    LOCAL    = 5'b10000
  } e_route;
  typedef enum logic [1:0] {BODY = 2'b00, TAIL = 2'b01, HEAD = 2'b10, SINGLE = 2'b11} e_flit_type;
  typedef enum logic [1:0] {IDLE, ROUTE, ACTIVE} e_vc_state;
  // X is resolved first, then Y; all coordinates compared unsigned
  function automatic e_route xy_route(input logic [31:0] dest_x, input logic [31:0] dest_y,
                                      input logic [31:0] cur_x, input logic [31:0] cur_y);
    if (dest_x > cur_x) return EAST;
    if (dest_x < cur_x) return WEST;
    if (dest_y > cur_y) return SOUTH;
    if (dest_y < cur_y) return NORTH;
    return LOCAL;
  endfunction
endpackage

// File: rtl/noc_input_vc_unit_fifo.sv
// noc_vc_fifo: single-clock FIFO; a write to a full FIFO is accepted only alongside a pop
module noc_vc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] front
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic do_wr, do_rd;
  assign do_rd = rd && !empty;
  assign do_wr = wr && (!full || do_rd);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign front = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (do_wr) mem[wp] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= do_wr ? wp + 1'b1 : wp;
      rp <= do_rd ? rp + 1'b1 : rp;
      count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
    end
endmodule

// File: rtl/noc_input_vc_unit.sv
// noc_input_vc_unit: router input port with per-VC FIFOs, per-packet XY route and credit return
module noc_input_vc_unit
  import noc_input_vc_unit_pkg::*;
#(
  parameter int FLIT_W   = Noc_Flit_Width,
  parameter int VC_NUM   = Noc_VC_Channel,
  parameter int DEPTH    = Noc_VC_Fifo_Depth,
  parameter int X_W      = Noc_ID_X_Width,
  parameter int Y_W      = Noc_ID_Y_Width,
  parameter int CUR_X    = 0,
  parameter int CUR_Y    = 0,
  parameter int DEST_LSB = Noc_Dest_Point
)(
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       in_valid,
  input  logic [(VC_NUM > 1 ? $clog2(VC_NUM) : 1)-1:0] in_vc,
  input  logic [FLIT_W-1:0]                          in_flit,
  output logic                                       credit_valid,
  output logic [(VC_NUM > 1 ? $clog2(VC_NUM) : 1)-1:0] credit_vc,
  output logic [VC_NUM-1:0]                          vc_valid,
  output logic [VC_NUM*FLIT_W-1:0]                   vc_flit,
  output logic [VC_NUM*5-1:0]                        vc_route,
  output logic [VC_NUM-1:0]                          vc_tail,
  input  logic [VC_NUM-1:0]                          vc_deq,
  output logic                                       overflow_err
);
  localparam int VC_W = VC_NUM > 1 ? $clog2(VC_NUM) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  logic [VC_NUM-1:0] full, empty, pop;
  logic [CW-1:0] cnt [VC_NUM];
  logic [VC_W-1:0] sel;
  logic grant;
  for (genvar i = 0; i < VC_NUM; i++) begin : g_vc
    e_vc_state state;
    e_route route;
    logic [FLIT_W-1:0] front;
    logic [1:0] ftype;
    assign ftype = front[FLIT_W-1 -: 2];
    // in IDLE a BODY/TAIL at the front is a stray flit and is discarded
    assign pop[i] = !empty[i] && (state == IDLE ? !ftype[1] : state == ACTIVE && vc_deq[i]);
    assign vc_valid[i] = state == ACTIVE && !empty[i];
    assign vc_tail[i] = ftype[0];
    assign vc_flit[i*FLIT_W +: FLIT_W] = front;
    assign vc_route[i*5 +: 5] = route;
    noc_vc_fifo #(.WIDTH(FLIT_W), .DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst_n(rst_n),
      .wr(in_valid && in_vc == VC_W'(i)),
      .rd(pop[i]),
      .din(in_flit),
      .full(full[i]),
      .empty(empty[i]),
      .front(front)
    );
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        state <= IDLE;
        route <= ROUTE_NA;
      end else if (state == IDLE) begin
        if (!empty[i] && ftype[1]) state <= ROUTE;
      end else if (state == ROUTE) begin
        route <= xy_route(32'(front[DEST_LSB +: X_W]), 32'(front[DEST_LSB+X_W +: Y_W]),
                          32'(CUR_X), 32'(CUR_Y));
        state <= ACTIVE;
      end else if (pop[i] && ftype[0]) begin
        state <= IDLE;
        route <= ROUTE_NA;
      end
  end
  // lowest VC with a pending or just-popped credit wins this cycle's credit slot
  always_comb begin
    sel = '0;
    grant = 1'b0;
    for (int i = VC_NUM - 1; i >= 0; i--)
      if (cnt[i] != '0 || pop[i]) begin
        sel = VC_W'(i);
        grant = 1'b1;
      end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      credit_valid <= 1'b0;
      credit_vc <= '0;
      overflow_err <= 1'b0;
      for (int i = 0; i < VC_NUM; i++) cnt[i] <= '0;
    end else begin
      credit_valid <= grant;
      credit_vc <= sel;
      overflow_err <= overflow_err || (in_valid && full[in_vc] && !pop[in_vc]);
      for (int i = 0; i < VC_NUM; i++)
        cnt[i] <= cnt[i] + CW'(pop[i]) - CW'(grant && sel == VC_W'(i));
    end
endmodule
